// File: rtl/fetch_queue_unit.sv
// Decoupled fetch front end: credit-limited icache request issue, prefetch FIFO
// drained to decode, redirect flush with stale-response squashing, ECALL halt.
module fetch_queue_unit #(
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [63:0] RESET_PC        = 64'h0,
    parameter logic [31:0] ECALL_INST      = 32'h00000073
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           fetch_enable,
    input  logic                           redirect_valid,
    input  logic [63:0]                    redirect_pc,
    output logic                           ic_req_valid,
    input  logic                           ic_req_ready,
    output logic [63:0]                    ic_req_addr,
    input  logic                           ic_resp_valid,
    input  logic [31:0]                    ic_resp_inst,
    input  logic [63:0]                    ic_resp_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instruction,
    output logic [63:0]                    out_pc,
    output logic                           ecall_detected,
    output logic                           in_flight,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int                PW       = $clog2(QUEUE_DEPTH);
    localparam int                CW       = PW + 1;
    localparam logic [CW-1:0]     MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]       DEPTH_C   = (CW+1)'(QUEUE_DEPTH);

    logic [31:0]   r_instMem [QUEUE_DEPTH];
    logic [63:0]   r_pcMem   [QUEUE_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_dropCnt;
    logic [63:0]   r_fetchPc;
    logic          r_halted;
    logic          r_ecall;

    logic          w_credit;
    logic          w_fire;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_isEcall;
    logic [CW-1:0] w_outNext;

    // Every in-flight request holds a reserved FIFO slot, so responses never overflow.
    assign w_credit  = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_C;

    assign ic_req_valid = fetch_enable & ~r_halted & ~redirect_valid
                        & (r_outstanding < MAX_OUT_C) & w_credit;
    assign ic_req_addr  = r_fetchPc;

    assign w_fire    = ic_req_valid & ic_req_ready;
    assign w_push    = ic_resp_valid & ~redirect_valid & (r_dropCnt == '0);
    assign w_drop    = ic_resp_valid & ~redirect_valid & (r_dropCnt != '0);
    assign w_isEcall = w_push & (ic_resp_inst == ECALL_INST);

    assign out_valid       = (r_count != '0) & ~redirect_valid;
    assign w_pop           = out_valid & out_ready;
    assign out_instruction = out_valid ? r_instMem[r_rdPtr] : '0;
    assign out_pc          = out_valid ? r_pcMem[r_rdPtr]   : '0;

    assign ecall_detected = r_ecall;
    assign in_flight      = (r_outstanding != '0);
    assign queue_count    = r_count;

    always_comb begin
        w_outNext = r_outstanding;
        if (w_fire && !ic_resp_valid) begin
            w_outNext = r_outstanding + CW'(1);
        end else if (!w_fire && ic_resp_valid) begin
            w_outNext = r_outstanding - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instMem[r_wrPtr] <= ic_resp_inst;
            r_pcMem[r_wrPtr]   <= ic_resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_dropCnt     <= '0;
            r_fetchPc     <= RESET_PC;
            r_halted      <= 1'b0;
            r_ecall       <= 1'b0;
        end else begin
            r_outstanding <= w_outNext;
            if (redirect_valid) begin
                // No request fires here, so w_outNext is exactly the stale responses still due.
                r_wrPtr   <= '0;
                r_rdPtr   <= '0;
                r_count   <= '0;
                r_fetchPc <= redirect_pc;
                r_halted  <= 1'b0;
                r_ecall   <= 1'b0;
                r_dropCnt <= w_outNext;
            end else begin
                if (w_fire) begin
                    r_fetchPc <= r_fetchPc + 64'd4;
                end
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PW'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
                if (w_isEcall) begin
                    r_halted  <= 1'b1;
                    r_ecall   <= 1'b1;
                    r_dropCnt <= w_outNext;
                end else if (w_drop) begin
                    r_dropCnt <= r_dropCnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a small in-order icache model whose
// responses can be held back to build up requests in flight.
module tb_fetch_queue_unit;

    logic        clk;
    logic        reset;
    logic        fetchEnable;
    logic        redirectValid;
    logic [63:0] redirectPc;
    logic        icReqValid;
    logic        icReqReady;
    logic [63:0] icReqAddr;
    logic        icRespValid;
    logic [31:0] icRespInst;
    logic [63:0] icRespPc;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstruction;
    logic [63:0] outPc;
    logic        ecallDetected;
    logic        inFlight;
    logic [2:0]  queueCount;

    logic        respHold;
    logic        ecallArm;
    logic [63:0] ecallPc;
    logic [63:0] pend[$];

    int checkCount = 0;
    int failCount  = 0;

    fetch_queue_unit dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_enable    (fetchEnable),
        .redirect_valid  (redirectValid),
        .redirect_pc     (redirectPc),
        .ic_req_valid    (icReqValid),
        .ic_req_ready    (icReqReady),
        .ic_req_addr     (icReqAddr),
        .ic_resp_valid   (icRespValid),
        .ic_resp_inst    (icRespInst),
        .ic_resp_pc      (icRespPc),
        .out_valid       (outValid),
        .out_ready       (outReady),
        .out_instruction (outInstruction),
        .out_pc          (outPc),
        .ecall_detected  (ecallDetected),
        .in_flight       (inFlight),
        .queue_count     (queueCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instOf(input logic [63:0] pc);
        if (ecallArm && pc == ecallPc) return 32'h00000073;
        return 32'hA0000000 + pc[31:0];
    endfunction

    // In-order icache: one-cycle latency per accepted request unless held back.
    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            icRespValid <= 1'b0;
            icRespInst  <= '0;
            icRespPc    <= '0;
        end else begin
            if (icRespValid) pend.pop_front();
            if (icReqValid && icReqReady) pend.push_back(icReqAddr);
            if (!respHold && pend.size() > 0) begin
                icRespValid <= 1'b1;
                icRespPc    <= pend[0];
                icRespInst  <= instOf(pend[0]);
            end else begin
                icRespValid <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Leaves the DUT freshly out of reset at a falling edge, all drives idle.
    task automatic applyStimulus();
        reset         = 1'b1;
        fetchEnable   = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = '0;
        outReady      = 1'b0;
        respHold      = 1'b0;
        ecallArm      = 1'b0;
        waitCycles(2);
        reset = 1'b0;
    endtask

    initial begin
        int          pops;
        logic [63:0] expPc;
        icReqReady = 1'b1;
        ecallPc    = '0;
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput("rst queue_count", queueCount, 0);
        checkOutput("rst out_valid", outValid, 0);
        checkOutput("rst in_flight", inFlight, 0);
        checkOutput("rst ecall", ecallDetected, 0);
        checkOutput("rst req_valid", icReqValid, 0);
        checkOutput("rst req_addr", icReqAddr, 64'h0);

        // Streaming fetch with decode always ready
        fetchEnable = 1'b1;
        outReady    = 1'b1;
        #1;
        checkOutput("T1 req_valid", icReqValid, 1);
        checkOutput("T1 addr0", icReqAddr, 64'h0);
        waitCycles(1);
        checkOutput("T1 addr1", icReqAddr, 64'h4);
        checkOutput("T1 in_flight", inFlight, 1);
        checkOutput("T1 no out yet", outValid, 0);
        waitCycles(1);
        checkOutput("T1 out_valid", outValid, 1);
        checkOutput("T1 out_pc0", outPc, 64'h0);
        checkOutput("T1 out_inst0", outInstruction, 32'hA0000000);
        checkOutput("T1 count", queueCount, 1);
        checkOutput("T1 addr2", icReqAddr, 64'h8);
        for (int i = 1; i < 4; i++) begin
            waitCycles(1);
            checkOutput("T1 out_pc", outPc, 64'(4 * i));
        end

        // Backpressure from decode until the credit limit stops issue
        outReady = 1'b0;
        waitCycles(2);
        checkOutput("T2 stall req_valid", icReqValid, 0);
        checkOutput("T2 count3", queueCount, 3);
        checkOutput("T2 in_flight", inFlight, 1);
        waitCycles(1);
        checkOutput("T2 count4", queueCount, 4);
        checkOutput("T2 drained flight", inFlight, 0);
        checkOutput("T2 req_valid full", icReqValid, 0);
        checkOutput("T2 head", outPc, 64'hC);
        waitCycles(1);
        checkOutput("T2 count held", queueCount, 4);
        checkOutput("T2 req_valid held", icReqValid, 0);
        outReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("T2 drain order", outPc, 64'(32'hC + 4 * i));
            waitCycles(1);
        end

        // Redirect with two requests in flight
        applyStimulus();
        fetchEnable = 1'b1;
        outReady    = 1'b1;
        respHold    = 1'b1;
        waitCycles(2);
        checkOutput("T3 two in flight", inFlight, 1);
        checkOutput("T3 limit req_valid", icReqValid, 0);
        redirectValid = 1'b1;
        redirectPc    = 64'h100;
        respHold      = 1'b0;
        waitCycles(1);
        redirectValid = 1'b0;
        #1;
        checkOutput("T3 flushed count", queueCount, 0);
        checkOutput("T3 new addr", icReqAddr, 64'h100);
        checkOutput("T3 still limited", icReqValid, 0);
        checkOutput("T3 out_valid0", outValid, 0);
        waitCycles(1);
        checkOutput("T3 one dropped", inFlight, 1);
        checkOutput("T3 issue 0x100", icReqValid, 1);
        checkOutput("T3 stale not out", outValid, 0);
        waitCycles(1);
        checkOutput("T3 second stale dropped", outValid, 0);
        waitCycles(1);
        checkOutput("T3 out_valid", outValid, 1);
        checkOutput("T3 first pc", outPc, 64'h100);
        waitCycles(1);
        checkOutput("T3 second pc", outPc, 64'h104);

        // ECALL returned at 0x8 with 0xC still in flight
        applyStimulus();
        ecallPc     = 64'h8;
        ecallArm    = 1'b1;
        fetchEnable = 1'b1;
        outReady    = 1'b1;
        waitCycles(3);
        checkOutput("T4 no ecall yet", ecallDetected, 0);
        waitCycles(1);
        checkOutput("T4 ecall", ecallDetected, 1);
        checkOutput("T4 ecall pc", outPc, 64'h8);
        checkOutput("T4 ecall inst", outInstruction, 32'h00000073);
        checkOutput("T4 halted req", icReqValid, 0);
        checkOutput("T4 0xC in flight", inFlight, 1);
        waitCycles(1);
        checkOutput("T4 0xC dropped", outValid, 0);
        checkOutput("T4 count0", queueCount, 0);
        checkOutput("T4 flight0", inFlight, 0);
        waitCycles(3);
        checkOutput("T4 still halted", icReqValid, 0);
        checkOutput("T4 ecall sticky", ecallDetected, 1);
        ecallArm      = 1'b0;
        redirectValid = 1'b1;
        redirectPc    = 64'h200;
        waitCycles(1);
        redirectValid = 1'b0;
        #1;
        checkOutput("T4 ecall cleared", ecallDetected, 0);
        checkOutput("T4 resume", icReqValid, 1);
        checkOutput("T4 resume addr", icReqAddr, 64'h200);

        // Push and pop together at DEPTH-1, then stream across several pointer wraps
        applyStimulus();
        fetchEnable = 1'b1;
        waitCycles(4);
        checkOutput("T5 count3", queueCount, 3);
        checkOutput("T5 in_flight", inFlight, 1);
        checkOutput("T5 credit stop", icReqValid, 0);
        outReady = 1'b1;
        waitCycles(1);
        checkOutput("T5 count stable", queueCount, 3);
        checkOutput("T5 head", outPc, 64'h4);
        expPc = 64'h4;
        pops  = 0;
        for (int c = 0; c < 60 && pops < 12; c++) begin
            if (outValid) begin
                checkOutput("T5 order", outPc, expPc);
                expPc = expPc + 64'h4;
                pops++;
            end
            waitCycles(1);
        end
        checkOutput("T5 pop total", 64'(pops), 64'd12);

        // Reset while the queue holds three entries
        applyStimulus();
        fetchEnable = 1'b1;
        waitCycles(4);
        checkOutput("T6 pre count", queueCount, 3);
        checkOutput("T6 pre flight", inFlight, 1);
        reset       = 1'b1;
        fetchEnable = 1'b0;
        waitCycles(1);
        checkOutput("T6 count", queueCount, 0);
        checkOutput("T6 out_valid", outValid, 0);
        checkOutput("T6 in_flight", inFlight, 0);
        checkOutput("T6 ecall", ecallDetected, 0);
        checkOutput("T6 req_valid", icReqValid, 0);
        checkOutput("T6 req_addr", icReqAddr, 64'h0);
        checkOutput("T6 out_pc", outPc, 64'h0);
        checkOutput("T6 out_inst", outInstruction, 32'h0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
